// File: rtl/mem_access_ctrl_if.sv
// Avalon-style memory bus between the access controller (master) and memory (slave).
interface mem_access_ctrl_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Arbitrates fetch and load/store requests onto one Avalon bus (data first), placing lanes,
// handling waitrequest with a saturating timeout, and returning raw read data.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic [3:0]        d_be,
    output logic              d_err,
    output logic              stall,
    mem_access_ctrl_if.master avm
);

    typedef enum logic [2:0] {StIdle, StFetch, StDRead, StDWrite, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [7:0]  wait_q, wait_d;
    logic        if_done_q, if_done_d;
    logic        d_done_q, d_done_d;
    logic        d_err_q, d_err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic [3:0]  d_be_q, d_be_d;

    logic [3:0]  d_lanes;
    logic [31:0] d_lane_data;
    logic        d_misalign;
    logic [7:0]  wait_inc;
    logic        abort;

    // Memory is byte-swapped, so store data is mirrored into the lanes.
    always_comb begin
        d_misalign  = 1'b0;
        d_lanes     = 4'b1111;
        d_lane_data = {d_wdata[7:0], d_wdata[15:8], d_wdata[23:16], d_wdata[31:24]};
        case (d_size)
            2'b00: begin
                d_lanes     = 4'b0001 << d_addr[1:0];
                d_lane_data = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                d_lanes     = d_addr[1] ? 4'b1100 : 4'b0011;
                d_lane_data = {2{d_wdata[7:0], d_wdata[15:8]}};
                d_misalign  = d_addr[0];
            end
            default: d_misalign = |d_addr[1:0];
        endcase
    end

    assign wait_inc = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
    assign abort    = (TIMEOUT != 0) && (32'(wait_inc) >= TIMEOUT);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        read_d     = read_q;
        write_d    = write_q;
        wait_d     = wait_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        d_err_d    = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        d_be_d     = d_be_q;

        unique case (state_q)
            StIdle: begin
                wait_d = 8'd0;
                if (d_req) begin
                    d_be_d = d_lanes;
                    if (d_misalign) begin
                        state_d   = StResp;
                        d_done_d  = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = 32'd0;
                    end else begin
                        state_d = d_we ? StDWrite : StDRead;
                        addr_d  = {d_addr[31:2], 2'b00};
                        be_d    = d_lanes;
                        wdata_d = d_we ? d_lane_data : 32'd0;
                        read_d  = !d_we;
                        write_d = d_we;
                    end
                end else if (if_req) begin
                    if (|if_addr[1:0]) begin
                        state_d    = StResp;
                        if_done_d  = 1'b1;
                        if_rdata_d = 32'd0;
                    end else begin
                        state_d = StFetch;
                        addr_d  = {if_addr[31:2], 2'b00};
                        be_d    = 4'b1111;
                        wdata_d = 32'd0;
                        read_d  = 1'b1;
                    end
                end
            end
            StFetch, StDRead, StDWrite: begin
                if (!avm.waitrequest || abort) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = StResp;
                    if (state_q == StFetch) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = avm.waitrequest ? 32'd0 : avm.readdata;
                    end else begin
                        d_done_d = 1'b1;
                        d_err_d  = avm.waitrequest;
                        if (avm.waitrequest) begin
                            d_rdata_d = 32'd0;
                        end else if (state_q == StDRead) begin
                            d_rdata_d = avm.readdata;
                        end
                    end
                end else begin
                    wait_d = wait_inc;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            wait_q     <= 8'd0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            d_err_q    <= 1'b0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
            d_be_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            read_q     <= read_d;
            write_q    <= write_d;
            wait_q     <= wait_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
            d_err_q    <= d_err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            d_be_q     <= d_be_d;
        end
    end

    assign avm.address    = addr_q;
    assign avm.read       = read_q;
    assign avm.write      = write_q;
    assign avm.writedata  = wdata_q;
    assign avm.byteenable = be_q;

    assign if_done  = if_done_q;
    assign if_rdata = if_rdata_q;
    assign d_done   = d_done_q;
    assign d_err    = d_err_q;
    assign d_rdata  = d_rdata_q;
    assign d_be     = d_be_q;
    assign stall    = (if_req | d_req) && !(if_done_q | d_done_q);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a table of single data accesses plus hand-written
// sequences for arbitration, timeout, misaligned fetch and mid-transfer reset.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, if_done, d_req, d_we, d_done, d_err, stall;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic [3:0]  d_be;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_ctrl_if avm ();

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_size   (d_size),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .d_be     (d_be),
        .d_err    (d_err),
        .stall    (stall),
        .avm      (avm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem;
        int          waits;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_data(input int idx, input vec_t v);
        int          cyc;
        int          strobes;
        bit          seen_done;
        bit          stall_ok;
        bit          no_fetch;
        logic        got_wr;
        logic [31:0] got_addr;
        logic [31:0] got_wd;
        logic [3:0]  got_be;
        @(negedge clk);
        d_req = 1'b1; d_we = v.we; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
        avm.readdata = v.mem;
        avm.waitrequest = (v.waits > 0);
        cyc = 0; strobes = 0; seen_done = 0; stall_ok = 1; no_fetch = 1;
        got_wr = 1'b0; got_addr = '0; got_wd = '0; got_be = '0;
        while (!seen_done && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (avm.read || avm.write) begin
                strobes++;
                if (strobes == 1) begin
                    got_wr = avm.write; got_addr = avm.address;
                    got_wd = avm.writedata; got_be = avm.byteenable;
                end
                avm.waitrequest = (strobes <= v.waits);
            end
            if (stall !== !(d_done || if_done)) stall_ok = 0;
            if (if_done) no_fetch = 0;
            if (d_done) seen_done = 1;
        end
        check($sformatf("v%0d_done_seen", idx), 32'(seen_done), 32'd1);
        check($sformatf("v%0d_latency", idx), cyc, v.exp_err ? 1 : v.waits + 2);
        check($sformatf("v%0d_err", idx), 32'(d_err), 32'(v.exp_err));
        check($sformatf("v%0d_strobes", idx), strobes, v.exp_err ? 0 : v.waits + 1);
        check($sformatf("v%0d_stall", idx), 32'(stall_ok), 32'd1);
        check($sformatf("v%0d_no_if_done", idx), 32'(no_fetch), 32'd1);
        if (!v.exp_err) begin
            check($sformatf("v%0d_avm_addr", idx), got_addr, {v.addr[31:2], 2'b00});
            check($sformatf("v%0d_avm_be", idx), 32'(got_be), 32'(v.exp_be));
            check($sformatf("v%0d_d_be", idx), 32'(d_be), 32'(v.exp_be));
            check($sformatf("v%0d_dir", idx), 32'(got_wr), 32'(v.we));
            if (v.we) check($sformatf("v%0d_wdata", idx), got_wd, v.exp_wd);
            else      check($sformatf("v%0d_rdata", idx), d_rdata, v.mem);
        end
        d_req = 1'b0;
        avm.waitrequest = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("v%0d_single_done", idx), 32'(d_done), 32'd0);
    endtask

    initial begin
        int          cyc;
        int          n_rd;
        int          d_at;
        int          if_at;
        bit          both;
        bit          stall_ok;
        bit          quiet;
        logic [31:0] a0;
        logic [31:0] a1;

        //        we    size   addr          wdata         mem           w  err   be       wd
        vecs[0]  = '{1'b0, 2'b10, 32'h0000_1004, 32'h0,        32'hDDCCBBAA, 0, 1'b0, 4'b1111, 32'h0};
        vecs[1]  = '{1'b1, 2'b00, 32'h0000_2003, 32'h0000_005A, 32'h0,       2, 1'b0, 4'b1000, 32'h5A5A5A5A};
        vecs[2]  = '{1'b1, 2'b10, 32'h0000_0100, 32'h1122_3344, 32'h0,       0, 1'b0, 4'b1111, 32'h44332211};
        vecs[3]  = '{1'b1, 2'b01, 32'h0000_0202, 32'hABCD_1234, 32'h0,       1, 1'b0, 4'b1100, 32'h34123412};
        vecs[4]  = '{1'b1, 2'b01, 32'h0000_0200, 32'h0000_BEEF, 32'h0,       0, 1'b0, 4'b0011, 32'hEFBEEFBE};
        vecs[5]  = '{1'b0, 2'b00, 32'h0000_0401, 32'h0,        32'h12345678, 1, 1'b0, 4'b0010, 32'h0};
        vecs[6]  = '{1'b0, 2'b01, 32'h0000_3001, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0};
        vecs[7]  = '{1'b1, 2'b10, 32'h0000_0102, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0};
        vecs[8]  = '{1'b0, 2'b11, 32'h0000_0050, 32'h0,        32'h87654321, 3, 1'b0, 4'b1111, 32'h0};
        vecs[9]  = '{1'b0, 2'b00, 32'h0000_0052, 32'h0,        32'hA5A5_0F0F, 0, 1'b0, 4'b0100, 32'h0};
        vecs[10] = '{1'b1, 2'b00, 32'h0000_0001, 32'hFFFF_FF77, 32'h0,       0, 1'b0, 4'b0010, 32'h77777777};

        reset_n = 1'b0;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_size = '0;
        d_addr = '0; d_wdata = '0;
        avm.waitrequest = 1'b0; avm.readdata = '0;

        repeat (2) @(negedge clk);
        check("rst_strobes", {30'd0, avm.read, avm.write}, 32'd0);
        check("rst_address", avm.address, 32'd0);
        check("rst_be_wd", {28'd0, avm.byteenable} | avm.writedata, 32'd0);
        check("rst_done_err", {29'd0, if_done, d_done, d_err}, 32'd0);
        check("rst_rdata", if_rdata | d_rdata | {28'd0, d_be}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) run_data(i, vecs[i]);

        // Simultaneous fetch and load: data goes first, fetch follows via IDLE.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h10;
        avm.readdata = 32'hCAFEF00D; avm.waitrequest = 1'b0;
        cyc = 0; n_rd = 0; d_at = 0; if_at = 0; both = 0; stall_ok = 1; a0 = '1; a1 = '1;
        while (if_at == 0 && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (avm.read) begin
                if (n_rd == 0) a0 = avm.address;
                else if (n_rd == 1) a1 = avm.address;
                n_rd++;
            end
            if (d_done && if_done) both = 1;
            if (stall !== !(d_done || if_done)) stall_ok = 0;
            if (d_done) begin
                d_at = cyc; d_req = 1'b0; avm.readdata = 32'h0BADC0DE;
            end
            if (if_done) if_at = cyc;
        end
        if_req = 1'b0;
        check("arb_d_done_cycle", d_at, 2);
        check("arb_if_done_cycle", if_at, 5);
        check("arb_first_addr", a0, 32'h10);
        check("arb_second_addr", a1, 32'h0);
        check("arb_reads", n_rd, 2);
        check("arb_if_rdata", if_rdata, 32'h0BADC0DE);
        check("arb_d_rdata", d_rdata, 32'hCAFEF00D);
        check("arb_stall", 32'(stall_ok), 32'd1);
        check("arb_one_done", 32'(both), 32'd0);

        // Timeout with waitrequest stuck high.
        @(negedge clk);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h40;
        avm.waitrequest = 1'b1; avm.readdata = 32'h1234_5678;
        cyc = 0; n_rd = 0;
        while (!d_done && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (avm.read) n_rd++;
        end
        check("to_read_cycles", n_rd, 4);
        check("to_latency", cyc, 5);
        check("to_err", 32'(d_err), 32'd1);
        check("to_rdata", d_rdata, 32'd0);
        d_req = 1'b0; avm.waitrequest = 1'b0;

        // Misaligned fetch: no bus access, if_done in the next cycle.
        @(negedge clk);
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h6;
        @(posedge clk);
        @(negedge clk);
        check("mf_if_done", {30'd0, if_done, d_done}, 32'd2);
        check("mf_no_read", 32'(avm.read), 32'd0);
        if_req = 1'b0;

        // Reset in the middle of a stalled store.
        @(negedge clk);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h80; d_wdata = 32'h0102_0304;
        avm.waitrequest = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("rs_write_before", 32'(avm.write), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rs_write_dropped", 32'(avm.write), 32'd0);
        check("rs_no_done", 32'(d_done), 32'd0);
        d_req = 1'b0; avm.waitrequest = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        quiet = 1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (d_done || if_done || avm.read || avm.write) quiet = 0;
        end
        check("rs_quiet_after", 32'(quiet), 32'd1);
        run_data(20, vecs[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
